// File: rtl/pc_unit_pkg.sv
// rtl/pc_unit_pkg.sv - shared state encodings and address constants for the PC stage
package pc_unit_pkg;

  // FSM encodings; BOOT is the reset state, HALTED freezes fetch.
  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } pc_state_e;

  // Default byte increment per instruction.
  localparam int unsigned INSTR_BYTES_DEF = 4;

  // Low address bits that must be zero for a word-aligned fetch address.
  localparam int unsigned ALIGN_MASK = 3;

endpackage

// File: rtl/pc_unit_next_sel.sv
// rtl/pc_unit_next_sel.sv - combinational next-PC mux with halt/stall/branch priority
module pc_next_sel
  import pc_unit_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned INSTR_BYTES = INSTR_BYTES_DEF
) (
  input  pc_state_e          state,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               brType,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               link,
  input  logic               stall,
  input  logic               halt,
  input  logic               resume,
  output logic [ADDR_W-1:0]  next_pc,
  output logic [ADDR_W-1:0]  seq_pc,
  output logic               redirect,
  output logic               link_write
);

  logic [ADDR_W-1:0] aligned_target;

  // Sequential address wraps naturally modulo 2^ADDR_W; branch targets lose their low bits.
  always_comb begin
    seq_pc         = pc + ADDR_W'(INSTR_BYTES);
    aligned_target = br_target & ~ADDR_W'(ALIGN_MASK);
  end

  // Select the next fetch address; hold is the default for every non-advancing case.
  always_comb begin
    next_pc    = pc;
    redirect   = 1'b0;
    link_write = 1'b0;
    case (state)
      ST_RUN: begin
        if (halt) begin
          next_pc = pc;
        end else if (stall) begin
          next_pc = pc;
        end else if (brType) begin
          next_pc    = aligned_target;
          redirect   = 1'b1;
          link_write = link;
        end else begin
          next_pc = seq_pc;
        end
      end
      ST_HALTED: begin
        if (resume) begin
          next_pc = seq_pc;
        end
      end
      default: begin
        next_pc = pc;
      end
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter stage with flush, branch-and-link and halt/resume
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned     ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned     INSTR_BYTES = INSTR_BYTES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              brType,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              link,
  input  logic              stall,
  input  logic              halt,
  input  logic              resume,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_valid,
  output logic              flush,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_addr,
  output logic              halted
);

  pc_state_e         state;
  pc_state_e         state_next;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] seq_pc;
  logic              redirect;
  logic              link_write;

  pc_next_sel #(
    .ADDR_W      (ADDR_W),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_next_sel (
    .state      (state),
    .pc         (pc),
    .brType     (brType),
    .br_target  (br_target),
    .link       (link),
    .stall      (stall),
    .halt       (halt),
    .resume     (resume),
    .next_pc    (next_pc),
    .seq_pc     (seq_pc),
    .redirect   (redirect),
    .link_write (link_write)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: BOOT always advances, halt wins over everything in RUN.
  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT:   state_next = ST_RUN;
      ST_RUN:    if (halt) state_next = ST_HALTED;
      ST_HALTED: if (resume) state_next = ST_RUN;
      default:   state_next = ST_BOOT;
    endcase
  end

  // Output registers; strobes are recomputed every cycle so they last one cycle per redirect.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      pc_valid  <= 1'b0;
      flush     <= 1'b0;
      link_we   <= 1'b0;
      link_addr <= '0;
      halted    <= 1'b0;
    end else begin
      pc       <= next_pc;
      pc_valid <= (state_next == ST_RUN);
      flush    <= redirect;
      link_we  <= link_write;
      halted   <= (state_next == ST_HALTED);
      if (link_write) begin
        link_addr <= seq_pc;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - scoreboard testbench for pc_unit
module tb_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        brType;
  logic [31:0] br_target;
  logic        link;
  logic        stall;
  logic        halt;
  logic        resume;
  logic [31:0] pc;
  logic        pc_valid;
  logic        flush;
  logic        link_we;
  logic [31:0] link_addr;
  logic        halted;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        rn;
    logic        br;
    logic [31:0] tg;
    logic        lk;
    logic        st;
    logic        hl;
    logic        rs;
  } row_t;

  typedef struct {
    logic [31:0] pc;
    logic        pv;
    logic        fl;
    logic        lw;
    logic [31:0] la;
    logic        hl;
  } exp_t;

  exp_t sb[$];

  // reference model state: 0 boot, 1 run, 2 halted
  int          m_st;
  logic [31:0] m_pc;
  logic        m_pv;
  logic        m_fl;
  logic        m_lw;
  logic [31:0] m_la;
  logic        m_hl;

  pc_unit #(
    .ADDR_W      (32),
    .RESET_PC    (32'h0),
    .INSTR_BYTES (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .brType    (brType),
    .br_target (br_target),
    .link      (link),
    .stall     (stall),
    .halt      (halt),
    .resume    (resume),
    .pc        (pc),
    .pc_valid  (pc_valid),
    .flush     (flush),
    .link_we   (link_we),
    .link_addr (link_addr),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic row_t mk(logic rn, logic br, logic [31:0] tg, logic lk,
                              logic st, logic hl, logic rs);
    row_t r;
    r.rn = rn; r.br = br; r.tg = tg; r.lk = lk; r.st = st; r.hl = hl; r.rs = rs;
    return r;
  endfunction

  // Drive one cycle of inputs, advance the model, push the expected post-edge outputs.
  task automatic apply(row_t r);
    exp_t e;
    rst_n = r.rn; brType = r.br; br_target = r.tg; link = r.lk;
    stall = r.st; halt = r.hl; resume = r.rs;
    if (!r.rn) begin
      m_st = 0; m_pc = 32'h0; m_pv = 0; m_fl = 0; m_lw = 0; m_la = 32'h0; m_hl = 0;
    end else begin
      m_fl = 0;
      m_lw = 0;
      if (m_st == 0) begin
        m_st = 1; m_pv = 1; m_hl = 0;
      end else if (m_st == 1) begin
        if (r.hl) begin
          m_st = 2; m_pv = 0; m_hl = 1;
        end else if (r.st) begin
          m_pv = 1;
        end else if (r.br) begin
          if (r.lk) begin
            m_lw = 1;
            m_la = m_pc + 32'd4;
          end
          m_pc = {r.tg[31:2], 2'b00};
          m_fl = 1;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end else begin
        if (r.rs) begin
          m_st = 1; m_pc = m_pc + 32'd4; m_pv = 1; m_hl = 0;
        end
      end
    end
    e.pc = m_pc; e.pv = m_pv; e.fl = m_fl; e.lw = m_lw; e.la = m_la; e.hl = m_hl;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(0, 1, 32'h55, 1, 0, 0, 0));
    rows.push_back(mk(0, 0, 32'h0, 0, 0, 1, 0));
    rows.push_back(mk(1, 1, 32'h80, 1, 0, 0, 0));
    rows.push_back(mk(1, 0, 32'h0, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 32'h0, 0, 0, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if ({pc, pc_valid, flush, link_we, link_addr, halted} !== {e.pc, e.pv, e.fl, e.lw, e.la, e.hl}) begin
        n_fail++;
        $display("FAIL reset step %0d: got pc=%h v=%b fl=%b lw=%b la=%h h=%b want pc=%h v=%b fl=%b lw=%b la=%h h=%b",
                 i, pc, pc_valid, flush, link_we, link_addr, halted, e.pc, e.pv, e.fl, e.lw, e.la, e.hl);
      end
    end
    n_checks++;
    if (pc !== 32'h8 || pc_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_seq_end: got pc=%h v=%b want pc=00000008 v=1", pc, pc_valid);
    end
  endtask

  task automatic test_branch_link();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 1, 32'h10, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 32'h103, 1, 0, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if ({pc, pc_valid, flush, link_we, link_addr, halted} !== {e.pc, e.pv, e.fl, e.lw, e.la, e.hl}) begin
        n_fail++;
        $display("FAIL branch_link step %0d: got pc=%h v=%b fl=%b lw=%b la=%h h=%b want pc=%h v=%b fl=%b lw=%b la=%h h=%b",
                 i, pc, pc_valid, flush, link_we, link_addr, halted, e.pc, e.pv, e.fl, e.lw, e.la, e.hl);
      end
    end
    n_checks++;
    if (pc !== 32'h100 || flush !== 1'b1 || link_we !== 1'b1 || link_addr !== 32'h14) begin
      n_fail++;
      $display("FAIL branch_link_target: got pc=%h fl=%b lw=%b la=%h want pc=00000100 fl=1 lw=1 la=00000014",
               pc, flush, link_we, link_addr);
    end
    // link without a taken branch must not write
    rows.delete();
    rows.push_back(mk(1, 0, 32'h0, 1, 0, 0, 0));
    rows.push_back(mk(1, 0, 32'h0, 0, 0, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if ({pc, pc_valid, flush, link_we, link_addr, halted} !== {e.pc, e.pv, e.fl, e.lw, e.la, e.hl}) begin
        n_fail++;
        $display("FAIL branch_link_after step %0d: got pc=%h v=%b fl=%b lw=%b la=%h h=%b want pc=%h v=%b fl=%b lw=%b la=%h h=%b",
                 i, pc, pc_valid, flush, link_we, link_addr, halted, e.pc, e.pv, e.fl, e.lw, e.la, e.hl);
      end
    end
    n_checks++;
    if (pc !== 32'h108 || flush !== 1'b0 || link_we !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_link_seq: got pc=%h fl=%b lw=%b want pc=00000108 fl=0 lw=0", pc, flush, link_we);
    end
  endtask

  task automatic test_stall();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 1, 32'h20, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 32'h40, 1, 1, 0, 0));
    rows.push_back(mk(1, 1, 32'h40, 1, 1, 0, 0));
    rows.push_back(mk(1, 1, 32'h40, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 32'h0, 0, 1, 0, 0));
    rows.push_back(mk(1, 0, 32'h0, 0, 0, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if ({pc, pc_valid, flush, link_we, link_addr, halted} !== {e.pc, e.pv, e.fl, e.lw, e.la, e.hl}) begin
        n_fail++;
        $display("FAIL stall step %0d: got pc=%h v=%b fl=%b lw=%b la=%h h=%b want pc=%h v=%b fl=%b lw=%b la=%h h=%b",
                 i, pc, pc_valid, flush, link_we, link_addr, halted, e.pc, e.pv, e.fl, e.lw, e.la, e.hl);
      end
    end
  endtask

  task automatic test_halt_resume();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 1, 32'h30, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 32'h80, 1, 1, 1, 1));
    rows.push_back(mk(1, 1, 32'h90, 1, 0, 0, 0));
    rows.push_back(mk(1, 0, 32'h0, 0, 1, 1, 0));
    rows.push_back(mk(1, 1, 32'ha0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 32'hb0, 1, 1, 0, 1));
    rows.push_back(mk(1, 0, 32'h0, 0, 0, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if ({pc, pc_valid, flush, link_we, link_addr, halted} !== {e.pc, e.pv, e.fl, e.lw, e.la, e.hl}) begin
        n_fail++;
        $display("FAIL halt step %0d: got pc=%h v=%b fl=%b lw=%b la=%h h=%b want pc=%h v=%b fl=%b lw=%b la=%h h=%b",
                 i, pc, pc_valid, flush, link_we, link_addr, halted, e.pc, e.pv, e.fl, e.lw, e.la, e.hl);
      end
    end
    n_checks++;
    if (pc !== 32'h38 || halted !== 1'b0 || pc_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL halt_resume_end: got pc=%h h=%b v=%b want pc=00000038 h=0 v=1", pc, halted, pc_valid);
    end
  endtask

  task automatic test_wrap();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 32'h0, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 32'h200, 1, 0, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if ({pc, pc_valid, flush, link_we, link_addr, halted} !== {e.pc, e.pv, e.fl, e.lw, e.la, e.hl}) begin
        n_fail++;
        $display("FAIL wrap step %0d: got pc=%h v=%b fl=%b lw=%b la=%h h=%b want pc=%h v=%b fl=%b lw=%b la=%h h=%b",
                 i, pc, pc_valid, flush, link_we, link_addr, halted, e.pc, e.pv, e.fl, e.lw, e.la, e.hl);
      end
    end
    n_checks++;
    if (link_addr !== 32'h0 || link_we !== 1'b1 || pc !== 32'h200) begin
      n_fail++;
      $display("FAIL wrap_link: got la=%h lw=%b pc=%h want la=00000000 lw=1 pc=00000200", link_addr, link_we, pc);
    end
  endtask

  task automatic test_back_to_back();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 1, 32'h300, 0, 0, 0, 0));
    rows.push_back(mk(1, 1, 32'h300, 1, 0, 0, 0));
    rows.push_back(mk(1, 1, 32'h1234_5679, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++) begin
      rows.push_back(mk(1, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'b0, 1'b0));
    end
    rows.push_back(mk(1, 0, 32'h0, 0, 0, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if ({pc, pc_valid, flush, link_we, link_addr, halted} !== {e.pc, e.pv, e.fl, e.lw, e.la, e.hl}) begin
        n_fail++;
        $display("FAIL back_to_back step %0d: got pc=%h v=%b fl=%b lw=%b la=%h h=%b want pc=%h v=%b fl=%b lw=%b la=%h h=%b",
                 i, pc, pc_valid, flush, link_we, link_addr, halted, e.pc, e.pv, e.fl, e.lw, e.la, e.hl);
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    row_t rows[$];
    exp_t e;
    rows.push_back(mk(1, 1, 32'h400, 1, 0, 0, 0));
    rows.push_back(mk(0, 1, 32'h500, 1, 0, 0, 0));
    rows.push_back(mk(1, 1, 32'h600, 1, 0, 0, 0));
    rows.push_back(mk(1, 0, 32'h0, 0, 0, 1, 0));
    rows.push_back(mk(0, 0, 32'h0, 0, 0, 0, 1));
    rows.push_back(mk(1, 0, 32'h0, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 32'h0, 0, 0, 0, 0));
    for (int i = 0; i < rows.size(); i++) begin
      apply(rows[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_checks++;
      if ({pc, pc_valid, flush, link_we, link_addr, halted} !== {e.pc, e.pv, e.fl, e.lw, e.la, e.hl}) begin
        n_fail++;
        $display("FAIL reset_mid step %0d: got pc=%h v=%b fl=%b lw=%b la=%h h=%b want pc=%h v=%b fl=%b lw=%b la=%h h=%b",
                 i, pc, pc_valid, flush, link_we, link_addr, halted, e.pc, e.pv, e.fl, e.lw, e.la, e.hl);
      end
      if (i == 1) begin
        n_checks++;
        if ({pc, pc_valid, flush, link_we, link_addr, halted} !== {32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0}) begin
          n_fail++;
          $display("FAIL reset_mid_values: got pc=%h v=%b fl=%b lw=%b la=%h h=%b want all zero",
                   pc, pc_valid, flush, link_we, link_addr, halted);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_st = 0; m_pc = 32'h0; m_pv = 0; m_fl = 0; m_lw = 0; m_la = 32'h0; m_hl = 0;
    rst_n = 1'b0; brType = 1'b0; br_target = 32'h0; link = 1'b0;
    stall = 1'b0; halt = 1'b0; resume = 1'b0;
    #1;
    test_reset();
    test_branch_link();
    test_stall();
    test_halt_resume();
    test_wrap();
    test_back_to_back();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
